muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. It sits beside the single-cycle execute ALU and takes over MULT/MULTU/DIV/DIVU/MTHI/MTLO, so that long-latency arithmetic no longer sits in one combinational cycle. The decode stage issues operations through a start/busy/done handshake, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be at least 4.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: issue request, sampled on the rising edge.
- `op` in 3: operation code; encodings are in `muldiv_pkg`.
- `rs_data` in WIDTH: multiplicand or dividend; source for MTHI/MTLO.
- `rt_data` in WIDTH: multiplier or divisor.
- `abort` in 1: squash the in-flight operation (branch flush).
- `busy` out 1: operation in flight; new `start` is ignored.
- `done` out 1: one-cycle pulse when HI/LO are written by MULT/DIV.
- `div_by_zero` out 1: sticky flag, set by DIV/DIVU with `rt_data`=0, cleared by the next accepted start.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Opcodes:** MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5. Codes 6 and 7 are ignored: no state change.
- **Reset:** state IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, all internal registers cleared.
- **States:** IDLE, CALC, FIX.
  - IDLE to CALC: `start` with op 0–3.
  - CALC to FIX: after WIDTH iterations.
  - FIX to IDLE: always.
  - Any state to IDLE: `abort`=1.
- **MTHI/MTLO:** in IDLE with `start`, `hi` (or `lo`) takes `rs_data` at that edge. No busy, no done.
- **Accept (IDLE):**
  - Latch the op.
  - For signed ops, latch the magnitudes of the operands and the sign of the result (and of the remainder).
  - Clear the iteration counter ($clog2(WIDTH)+1 bits) and clear `div_by_zero`.
- **CALC, multiply:** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle. Remainder and quotient are held in a shared 2·WIDTH+1 shift register.
- **FIX:**
  - Apply two's-complement negation where the sign requires it.
  - Multiply: `hi`/`lo` take the upper/lower WIDTH bits of the 2·WIDTH product.
  - Divide: `lo` takes the quotient, truncated toward zero; `hi` takes the remainder, whose sign follows the dividend.
  - Register `done`=1.
- **Divide by zero:** skip the iterations. FIX writes `lo`=all ones and `hi`=dividend (signed/unsigned as given), and sets `div_by_zero`=1.
- **Signed overflow:** DIV of minimum-negative by −1 gives `lo`=minimum-negative and `hi`=0. No flag.
- **Abort:**
  - In CALC or FIX: return to IDLE; `hi`/`lo` unchanged; no done.
  - Abort together with `start` in IDLE: the start is dropped.
- **Start while busy:** ignored entirely, including MTHI/MTLO.

## Timing
- **Accept edge E0:** `busy`=1 is visible after E0.
- **Iterations:** CALC occupies edges E1..E_WIDTH.
- **Result edge E_(WIDTH+1):** FIX writes `hi`/`lo`, `done` goes to 1, `busy` goes to 0. With WIDTH=32 this is 33 edges after accept.
- **Divide by zero:** FIX at E1. `done` goes high after E1.
- **`done` pulse:** high exactly one cycle. A new `start` may be accepted on the edge on which `done` is high.
- **Back-to-back ops:** `done` drops and `busy` rises on the same edge.
- **MTHI/MTLO:** zero latency; the value is visible after the accept edge.
- **`reset_n` deasserted mid-operation:** immediate asynchronous clear to the reset values above, independent of `clock`.

## Structure
- `muldiv_pkg` holds:
  - the `md_op_t` opcode enum;
  - the state enum `md_state_t`;
  - the function `md_abs(x, is_signed)` returning magnitude and sign.
- Sub-module `muldiv_step` is one combinational iteration: shift-add or restore-compare on the shared accumulator, selected by a mode bit. The top holds the FSM, the counter, and the HI/LO registers.
- The ALU keeps MFHI/MFLO decode and muxes `hi`/`lo` onto its data output.

## Test plan
All scenarios use WIDTH=32.
- MULT, −3 × 5 → `done` after 33 edges; `hi`=FFFFFFFF, `lo`=FFFFFFF1; `busy` high for 33 cycles.
- MULTU, FFFFFFFF × FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001.
- DIVU, 100 ÷ 7 → `lo`=0000000E, `hi`=00000002. DIV, −7 ÷ 2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF. DIV, 80000000 ÷ FFFFFFFF → `lo`=80000000, `hi`=0.
- DIV, 5 ÷ 0 → `done` after the 2nd edge; `lo`=FFFFFFFF, `hi`=00000005, `div_by_zero`=1. The next MULTU clears the flag.
- MTHI 1234 → next MULT accepted; `start`+MTLO issued mid-CALC is ignored (`lo` unchanged); then `abort` at iteration 10 → IDLE, `hi`=1234, no done.
- `reset_n` low at iteration 20 of a DIVU → immediately `busy`=0, `hi`=`lo`=0. The op issued after release completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcode/state types and the operand-magnitude helper for the iterative multiply/divide unit.
// Operand widths up to MD_MAX_W are supported by md_abs.
package muldiv_pkg;

  localparam int MD_MAX_W = 64;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_t;

  // neg sits above mag so a size cast of the struct yields the magnitude bits
  typedef struct packed {
    logic                neg;
    logic [MD_MAX_W-1:0] mag;
  } md_abs_t;

  // x holds a w-bit operand zero-extended; only mag[w-1:0] is meaningful
  function automatic md_abs_t md_abs(input logic [MD_MAX_W-1:0] x, input int w, input logic is_signed);
    md_abs_t             r;
    logic [MD_MAX_W-1:0] msb_mask;
    msb_mask = MD_MAX_W'(1) << (w - 1);
    r.neg    = is_signed & (|(x & msb_mask));
    r.mag    = r.neg ? (~x + MD_MAX_W'(1)) : x;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step
// on the shared 2*WIDTH+1 accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    // multiply: acc = {partial product (W+1), remaining multiplier bits (W)}
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
    // divide: acc = {spare, remainder (W), quotient/dividend (W)}
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    trial     = {1'b0, rem_shift} - {2'b00, operand};
    acc_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (trial[WIDTH+1]) begin
        acc_next = {rem_shift, acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: sign-magnitude front end,
// WIDTH-cycle shift-add / restoring core, and a sign-fixup cycle before writeback.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t        state, state_next;
  md_op_t           cur_op;
  logic [CW-1:0]    count;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] step_next;
  logic [WIDTH-1:0] operand;
  logic             neg_res;
  logic             neg_rem;
  logic             zero_div;

  logic             accept;
  logic             arith_in;
  logic             div_in;
  logic             signed_in;
  logic             zero_div_in;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic             rs_neg;
  logic             rt_neg;
  logic             cur_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    accept      = (state == MD_IDLE) && start && !abort;
    arith_in    = (op < 3'd4);
    div_in      = (op == MD_DIV) || (op == MD_DIVU);
    signed_in   = (op == MD_MULT) || (op == MD_DIV);
    zero_div_in = div_in && (rt_data == '0);
    rs_mag      = WIDTH'(md_abs(MD_MAX_W'(rs_data), WIDTH, signed_in));
    rt_mag      = WIDTH'(md_abs(MD_MAX_W'(rt_data), WIDTH, signed_in));
    rs_neg      = 1'(md_abs(MD_MAX_W'(rs_data), WIDTH, signed_in) >> MD_MAX_W);
    rt_neg      = 1'(md_abs(MD_MAX_W'(rt_data), WIDTH, signed_in) >> MD_MAX_W);
    cur_div     = (cur_op == MD_DIV) || (cur_op == MD_DIVU);
    prod_fix    = neg_res ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    busy        = (state != MD_IDLE);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (cur_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (accept && arith_in) state_next = zero_div_in ? MD_FIX : MD_CALC;
      MD_CALC: if (count == CW'(WIDTH - 1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (abort) state_next = MD_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_op      <= MD_MULT;
      count       <= '0;
      acc         <= '0;
      operand     <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (op <= 3'd5) div_by_zero <= 1'b0;
        if (op == MD_MTHI) hi <= rs_data;
        if (op == MD_MTLO) lo <= rs_data;
        if (arith_in) begin
          cur_op   <= md_op_t'(op);
          count    <= '0;
          operand  <= rt_mag;
          neg_res  <= rs_neg ^ rt_neg;
          neg_rem  <= rs_neg;
          zero_div <= zero_div_in;
          // zero divisor preloads the fixed result: quotient all ones, remainder = |dividend|
          acc      <= zero_div_in ? {1'b0, rs_mag, {WIDTH{1'b1}}} : {(WIDTH + 1)'(0), rs_mag};
        end
      end else if (state == MD_CALC && !abort) begin
        acc   <= step_next;
        count <= count + CW'(1);
      end else if (state == MD_FIX && !abort) begin
        done <= 1'b1;
        if (!cur_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else begin
          hi <= rem_fix;
          lo <= zero_div ? {WIDTH{1'b1}} : quo_fix;
          if (zero_div) div_by_zero <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors push expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        chk({mon_e.name, "_dbz"}, 64'(div_by_zero), 64'(mon_e.dbz));
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ab);
    @(negedge clock);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    abort   = ab;
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz, input int exp_edges);
    int edges;
    int busy_cnt;
    bit seen;
    sb.push_back('{exp_hi, exp_lo, exp_dbz, name});
    drive(o, a, b, 1'b0);
    chk({name, "_busy_e0"}, 64'(busy), 64'd1);
    chk({name, "_done_e0"}, 64'(done), 64'd0);
    chk({name, "_dbz_e0"}, 64'(div_by_zero), 64'd0);
    edges    = 0;
    busy_cnt = 1;
    seen     = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clock);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        seen  = 1;
        edges = k;
      end
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no done in 100 edges, expected done after %0d", name, exp_edges);
    end else begin
      chk({name, "_latency"}, 64'(edges), 64'(exp_edges));
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_edges));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mult_m3x5", MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_op("mult_big", MD_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);
    run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
    run_op("div_5_0", MD_DIV, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("dbz_sticky", 64'(div_by_zero), 64'd1);
    run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 33);

    // MTHI, then a MULT that is squashed at iteration 10 with an ignored MTLO in between
    drive(MD_MTHI, 32'h00001234, 32'd0, 1'b0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    drive(MD_MULT, 32'd3, 32'd4, 1'b0);
    chk("abort_busy_e0", 64'(busy), 64'd1);
    drive(MD_MTLO, 32'h0000DEAD, 32'd0, 1'b0);
    chk("mtlo_busy_lo", 64'(lo), 64'h2A);
    chk("mtlo_busy_busy", 64'(busy), 64'd1);
    repeat (8) @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'h1234);
    chk("abort_lo", 64'(lo), 64'h2A);
    chk("abort_done", 64'(done), 64'd0);
    repeat (40) @(posedge clock);
    #1;
    chk("abort_quiet_busy", 64'(busy), 64'd0);

    drive(MD_MTLO, 32'h0000BEEF, 32'd0, 1'b1);
    chk("abort_start_mtlo", 64'(lo), 64'h2A);
    drive(MD_MULT, 32'd2, 32'd2, 1'b1);
    chk("abort_start_mult", 64'(busy), 64'd0);
    drive(3'd6, 32'h00005555, 32'd0, 1'b0);
    chk("op6_busy", 64'(busy), 64'd0);
    chk("op6_hi", 64'(hi), 64'h1234);
    chk("op6_lo", 64'(lo), 64'h2A);

    run_op("div_m8_0", MD_DIV, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1);
    run_op("divu_max_0", MD_DIVU, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1);

    // asynchronous reset in the middle of a DIVU
    drive(MD_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (19) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("divu_after_rst", MD_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);
    run_op("b2b_mult", MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
